// File: rtl/uart_word_tx.sv
// Word-to-byte transmit controller: buffers whole words in a small FIFO and sends each
// as a framed packet (optional header, payload in chosen order, optional XOR checksum).
module uart_word_tx #(
  parameter int          BYTES     = 4,
  parameter int          DEPTH     = 4,
  parameter int          MSB_FIRST = 0,
  parameter int          HDR_EN    = 1,
  parameter logic [7:0]  HDR       = 8'hA5,
  parameter int          CSUM_EN   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     word_valid,
  input  logic [8*BYTES-1:0]       word_data,
  output logic                     word_ready,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  input  logic                     tx_busy,
  input  logic                     tx_done,
  output logic                     word_sent,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     overflow,
  output logic [1:0]               dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int L  = BYTES + HDR_EN + CSUM_EN;
  localparam int IW = $clog2(L + 1);
  localparam logic [IW-1:0] LAST = IW'(L - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  // Handshakes: producer word is taken on word_valid && word_ready; the byte UART is
  // asked with a one-cycle tx_start and answers with a one-cycle tx_done.
  state_t state, state_n;

  logic [8*BYTES-1:0] mem [DEPTH];
  logic [AW:0]        wr_ptr, rd_ptr;
  logic [8*BYTES-1:0] hold;
  logic [IW-1:0]      idx;
  logic [7:0]         csum;
  logic               full, empty, push, pop;
  logic               done_ok, issue, fold_done, last_done;
  logic               is_hdr, is_csum, is_payload;
  logic [7:0]         pay_byte, sel_byte;
  int                 pay_idx;

  assign full       = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign empty      = wr_ptr == rd_ptr;
  assign word_ready = ~full;
  assign level      = wr_ptr - rd_ptr;
  assign push       = word_valid & ~full;
  assign dbg_state  = state;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= word_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  // A tx_done coinciding with our own tx_start belongs to nothing we issued.
  assign done_ok = tx_done & ~tx_start;

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (!empty) state_n = S_ISSUE;
      S_ISSUE: if (!tx_busy) state_n = S_WAIT;
      S_WAIT:  if (done_ok) state_n = (idx == LAST) ? S_IDLE : S_ISSUE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    pop       = (state == S_IDLE) & ~empty;
    issue     = (state == S_ISSUE) & ~tx_busy;
    fold_done = (state == S_WAIT) & done_ok;
    last_done = fold_done & (idx == LAST);
    busy      = state != S_IDLE;
  end

  assign pay_idx = int'(idx) - HDR_EN;

  always_comb begin
    pay_byte = 8'h00;
    for (int k = 0; k < BYTES; k++) begin
      if (((MSB_FIRST != 0) ? (BYTES - 1 - k) : k) == pay_idx) pay_byte = hold[8*k +: 8];
    end
    is_hdr     = (HDR_EN != 0) && (idx == '0);
    is_csum    = (CSUM_EN != 0) && (idx == LAST);
    is_payload = ~is_hdr & ~is_csum;
    sel_byte   = is_hdr ? HDR : (is_csum ? csum : pay_byte);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      hold      <= '0;
      idx       <= '0;
      csum      <= 8'h00;
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
      word_sent <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      tx_start  <= issue;
      word_sent <= last_done;
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (word_valid && full) overflow <= 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
        hold   <= mem[rd_ptr[AW-1:0]];
        idx    <= '0;
        csum   <= 8'h00;
      end
      if (issue) tx_data <= sel_byte;
      // tx_data still holds the byte just completed, so fold it directly.
      if (fold_done) begin
        if (is_payload) csum <= csum ^ tx_data;
        if (idx != LAST) idx <= idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: default-parameter instance plus a 2-byte MSB-first unframed
// instance, each driven by a simple byte-UART responder.
module tb_uart_word_tx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic        word_valid = 1'b0;
  logic [31:0] word_data  = 32'h0;
  logic        word_ready, tx_start, word_sent, busy, overflow;
  logic [7:0]  tx_data;
  logic        tx_busy, tx_done;
  logic [2:0]  level;
  logic [1:0]  dbg_state;

  // 2-byte MSB-first instance, no header, no checksum
  logic        word_valid2 = 1'b0;
  logic [15:0] word_data2  = 16'h0;
  logic        word_ready2, tx_start2, word_sent2, busy2, overflow2;
  logic [7:0]  tx_data2;
  logic        tx_busy2, tx_done2;
  logic [2:0]  level2;
  logic [1:0]  dbg_state2;

  uart_word_tx dut (
    .clk(clk), .rst(rst), .word_valid(word_valid), .word_data(word_data),
    .word_ready(word_ready), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .tx_done(tx_done), .word_sent(word_sent), .level(level),
    .busy(busy), .overflow(overflow), .dbg_state(dbg_state)
  );

  uart_word_tx #(.BYTES(2), .MSB_FIRST(1), .HDR_EN(0), .CSUM_EN(0)) dut2 (
    .clk(clk), .rst(rst), .word_valid(word_valid2), .word_data(word_data2),
    .word_ready(word_ready2), .tx_start(tx_start2), .tx_data(tx_data2),
    .tx_busy(tx_busy2), .tx_done(tx_done2), .word_sent(word_sent2), .level(level2),
    .busy(busy2), .overflow(overflow2), .dbg_state(dbg_state2)
  );

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0] exp_q[$];
  logic [7:0] cap_q[$];
  logic [7:0] cap2_q[$];
  int sent_cnt  = 0;
  int sent2_cnt = 0;
  int start_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // byte UART responders
  int         lat        = 10;
  bit         rand_lat   = 1'b0;
  logic       force_busy = 1'b0;
  logic       spur_done  = 1'b0;
  logic       m_busy = 1'b0, m_done = 1'b0, prev_start = 1'b0;
  int         m_cnt  = 0;
  logic [7:0] m_byte = 8'h00;

  assign tx_busy = m_busy | force_busy;
  assign tx_done = m_done | spur_done;

  always @(negedge clk) begin
    if (!rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_cnt = 0; prev_start = 1'b0;
    end else begin
      if (m_done) begin
        m_done = 1'b0;
        m_busy = 1'b0;
      end
      if (tx_start) begin
        start_cnt++;
        check("start_gap", 32'(prev_start), 32'd0);
        if (!m_busy) begin
          cap_q.push_back(tx_data);
          m_byte = tx_data;
          m_busy = 1'b1;
          m_cnt  = rand_lat ? $urandom_range(1, 12) : lat;
        end
      end else if (m_busy) begin
        if (m_cnt > 1) m_cnt--;
        else begin
          check("tx_data_hold", 32'(tx_data), 32'(m_byte));
          m_done = 1'b1;
        end
      end
      prev_start = tx_start;
    end
  end

  logic m2_busy = 1'b0, m2_done = 1'b0;
  int   m2_cnt  = 0;
  assign tx_busy2 = m2_busy;
  assign tx_done2 = m2_done;

  always @(negedge clk) begin
    if (!rst) begin
      m2_busy = 1'b0; m2_done = 1'b0; m2_cnt = 0;
    end else begin
      if (m2_done) begin
        m2_done = 1'b0;
        m2_busy = 1'b0;
      end
      if (tx_start2 && !m2_busy) begin
        cap2_q.push_back(tx_data2);
        m2_busy = 1'b1;
        m2_cnt  = 3;
      end else if (m2_busy) begin
        if (m2_cnt > 1) m2_cnt--;
        else m2_done = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (word_sent)  sent_cnt++;
    if (word_sent2) sent2_cnt++;
  end

  // reference packet: optional A5 header, payload in chosen order, XOR of payload
  task automatic build_packet(input logic [31:0] w, input int nb, input bit msb,
                              input bit hdr_en, input bit csum_en);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    if (hdr_en) exp_q.push_back(8'hA5);
    for (int k = 0; k < nb; k++) begin
      b = msb ? w[8*(nb-1-k) +: 8] : w[8*k +: 8];
      x = x ^ b;
      exp_q.push_back(b);
    end
    if (csum_en) exp_q.push_back(x);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    int t;
    t = 0;
    @(negedge clk);
    while (!word_ready && t < 2000) begin @(negedge clk); t++; end
    if (!word_ready) check("send_ready_timeout", 32'(word_ready), 32'd1);
    word_valid = 1'b1;
    word_data  = w;
    build_packet(w, 4, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    word_valid = 1'b0;
  endtask

  task automatic send_word2(input logic [15:0] w);
    int t;
    t = 0;
    @(negedge clk);
    while (!word_ready2 && t < 2000) begin @(negedge clk); t++; end
    if (!word_ready2) check("send2_ready_timeout", 32'(word_ready2), 32'd1);
    word_valid2 = 1'b1;
    word_data2  = w;
    build_packet({16'h0, w}, 2, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    word_valid2 = 1'b0;
  endtask

  task automatic wait_sent(input int target, input bit second, input string name);
    int t;
    t = 0;
    while ((second ? sent2_cnt : sent_cnt) < target && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if ((second ? sent2_cnt : sent_cnt) < target)
      check({name, "_timeout"}, 32'(second ? sent2_cnt : sent_cnt), 32'(target));
  endtask

  task automatic cmp_caps(input string name, input bit second);
    int n;
    logic [31:0] gv;
    n = second ? cap2_q.size() : cap_q.size();
    check({name, "_len"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      gv = 32'hDEAD_0000;
      if (i < n) gv = 32'(second ? cap2_q[i] : cap_q[i]);
      check($sformatf("%s_byte%0d", name, i), gv, 32'(exp_q[i]));
    end
  endtask

  typedef struct {
    logic [31:0] word;
    logic [47:0] bytes;   // first transmitted byte in the top 8 bits
  } vec_t;

  vec_t       vecs[6];
  logic [2:0] exp_lv[5];

  initial begin
    int tgt, s0, s1, n_start;
    logic [31:0] w;

    vecs[0] = '{32'h44332211, 48'hA5_11_22_33_44_44};
    vecs[1] = '{32'h00000000, 48'hA5_00_00_00_00_00};
    vecs[2] = '{32'hFFFFFFFF, 48'hA5_FF_FF_FF_FF_00};
    vecs[3] = '{32'h12345678, 48'hA5_78_56_34_12_08};
    vecs[4] = '{32'hDEADBEEF, 48'hA5_EF_BE_AD_DE_22};
    vecs[5] = '{32'h000000A5, 48'hA5_A5_00_00_00_A5};
    exp_lv  = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};

    // reset values
    idle(3);
    check("rst_word_ready", 32'(word_ready), 32'd1);
    check("rst_level",      32'(level),      32'd0);
    check("rst_tx_start",   32'(tx_start),   32'd0);
    check("rst_tx_data",    32'(tx_data),    32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_word_sent",  32'(word_sent),  32'd0);
    check("rst_overflow",   32'(overflow),   32'd0);
    check("rst_ready2",     32'(word_ready2), 32'd1);
    rst = 1'b1;
    idle(2);

    // table-driven single-word packets
    for (int i = 0; i < 6; i++) begin
      cap_q.delete();
      tgt = sent_cnt + 1;
      send_word(vecs[i].word);
      wait_sent(tgt, 1'b0, $sformatf("vec%0d", i));
      idle(3);
      check($sformatf("vec%0d_len", i), 32'(cap_q.size()), 32'd6);
      for (int b = 0; b < 6; b++)
        check($sformatf("vec%0d_byte%0d", i, b),
              (b < cap_q.size()) ? 32'(cap_q[b]) : 32'hDEAD_0000,
              32'(vecs[i].bytes[8*(5-b) +: 8]));
      check($sformatf("vec%0d_level", i), 32'(level), 32'd0);
      check($sformatf("vec%0d_busy", i),  32'(busy),  32'd0);
    end

    // randomized words with random gaps and random UART latency
    exp_q.delete(); cap_q.delete();
    rand_lat = 1'b1;
    tgt = sent_cnt;
    for (int i = 0; i < 20; i++) begin
      idle($urandom_range(0, 3));
      send_word($urandom);
      tgt++;
    end
    wait_sent(tgt, 1'b0, "rand");
    idle(5);
    cmp_caps("rand", 1'b0);
    rand_lat = 1'b0;

    // spurious done while idle, busy held in ISSUE with another spurious done
    exp_q.delete(); cap_q.delete();
    s0 = sent_cnt;
    @(negedge clk); spur_done = 1'b1;
    @(negedge clk); spur_done = 1'b0;
    idle(2);
    check("spur_idle_sent", 32'(sent_cnt), 32'(s0));
    check("spur_idle_busy", 32'(busy), 32'd0);
    force_busy = 1'b1;
    s0 = start_cnt;
    tgt = sent_cnt + 1;
    send_word(32'hA1B2C3D4);
    idle(5);
    spur_done = 1'b1;
    @(negedge clk); spur_done = 1'b0;
    idle(14);
    check("hold_no_start", 32'(start_cnt - s0), 32'd0);
    check("hold_busy",     32'(busy), 32'd1);
    force_busy = 1'b0;
    wait_sent(tgt, 1'b0, "hold");
    idle(3);
    check("hold_starts", 32'(start_cnt - s0), 32'd6);
    cmp_caps("hold", 1'b0);

    // five back-to-back words fill the FIFO, the sixth is dropped
    exp_q.delete(); cap_q.delete();
    s0 = sent_cnt;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("fill%0d_ready", i), 32'(word_ready), 32'd1);
      w = $urandom;
      word_valid = 1'b1;
      word_data  = w;
      build_packet(w, 4, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      check($sformatf("fill%0d_level", i), 32'(level), 32'(exp_lv[i]));
    end
    check("full_ready",   32'(word_ready), 32'd0);
    check("full_no_ovf",  32'(overflow),   32'd0);
    word_data = 32'hCAFE0006;
    @(negedge clk);
    word_valid = 1'b0;
    check("ovf_set",      32'(overflow), 32'd1);
    check("ovf_level",    32'(level),    32'd4);
    wait_sent(s0 + 5, 1'b0, "fill");
    idle(20);
    cmp_caps("fill", 1'b0);
    check("fill_sent",    32'(sent_cnt - s0), 32'd5);
    check("fill_level",   32'(level),      32'd0);
    check("fill_ready",   32'(word_ready), 32'd1);
    check("ovf_sticky",   32'(overflow),   32'd1);

    // reset while the 4th byte of a packet is being started, two words queued
    exp_q.delete(); cap_q.delete();
    s0 = start_cnt;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      word_valid = 1'b1;
      word_data  = 32'h10203040 + i;
      @(negedge clk);
    end
    word_valid = 1'b0;
    n_start = 0;
    while (!(start_cnt - s0 >= 4 && tx_start) && n_start < 2000) begin
      @(negedge clk); #1;
      n_start++;
    end
    check("rst_mid_reached", 32'(start_cnt - s0), 32'd4);
    s1 = sent_cnt;
    rst = 1'b0;
    #1;
    check("arst_tx_start",  32'(tx_start),   32'd0);
    check("arst_busy",      32'(busy),       32'd0);
    check("arst_level",     32'(level),      32'd0);
    check("arst_ready",     32'(word_ready), 32'd1);
    check("arst_tx_data",   32'(tx_data),    32'd0);
    check("arst_overflow",  32'(overflow),   32'd0);
    check("arst_word_sent", 32'(word_sent),  32'd0);
    idle(2);
    rst = 1'b1;
    s0 = start_cnt;
    idle(30);
    check("arst_no_sent",  32'(sent_cnt),  32'(s1));
    check("arst_no_start", 32'(start_cnt), 32'(s0));
    exp_q.delete(); cap_q.delete();
    tgt = sent_cnt + 1;
    send_word(32'h0BADF00D);
    wait_sent(tgt, 1'b0, "after_rst");
    idle(3);
    check("after_rst_hdr", (cap_q.size() > 0) ? 32'(cap_q[0]) : 32'hDEAD_0000, 32'hA5);
    cmp_caps("after_rst", 1'b0);

    // 2-byte MSB-first unframed instance
    exp_q.delete(); cap2_q.delete();
    tgt = sent2_cnt + 1;
    send_word2(16'hBEEF);
    wait_sent(tgt, 1'b1, "beef");
    idle(3);
    check("beef_len",   32'(cap2_q.size()), 32'd2);
    check("beef_byte0", (cap2_q.size() > 0) ? 32'(cap2_q[0]) : 32'hDEAD_0000, 32'hBE);
    check("beef_byte1", (cap2_q.size() > 1) ? 32'(cap2_q[1]) : 32'hDEAD_0000, 32'hEF);
    exp_q.delete(); cap2_q.delete();
    tgt = sent2_cnt;
    for (int i = 0; i < 8; i++) begin
      send_word2(16'($urandom));
      tgt++;
    end
    wait_sent(tgt, 1'b1, "rand2");
    idle(5);
    cmp_caps("rand2", 1'b1);
    check("rand2_overflow", 32'(overflow2), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
